alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Downstream stage of the 16-bit ALU top. Samples the ALU's four result buses and their unit flags when the upstream sequencer strobes a valid operation. Packs the result of the single active unit into a tagged word and buffers it in a small FIFO. Results drain to the consumer over a valid/ready handshake; overflow drops and flag-encoding errors are counted and reported.

## Interface
- OP_WIDTH, 16, ALU operand width; the stored result is 2*OP_WIDTH bits.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  sequencer strobe; ALU outputs are sampled only on edges where it is 1.
- Arith_OUT  in  2*OP_WIDTH  signed arithmetic result.
- Arith_Flag  in  1  arithmetic unit active.
- Logic_OUT  in  OP_WIDTH  logic result.
- Logic_Flag  in  1  logic unit active.
- CMP_OUT  in  OP_WIDTH  compare result.
- CMP_Flag  in  1  compare unit active.
- SHIFT_OUT  in  OP_WIDTH  shift result.
- SHIFT_Flag  in  1  shift unit active.
- CLR  in  1  synchronous clear of the FIFO, counters and sticky flags.
- RES_DATA  out  2*OP_WIDTH  head-of-FIFO result.
- RES_TAG  out  2  head-of-FIFO unit tag: 00 arith, 01 logic, 10 cmp, 11 shift.
- RES_VALID  out  1  FIFO non-empty.
- RES_READY  in  1  consumer accepts the head entry.
- LEVEL  out  log2(DEPTH)+1  current occupancy.
- FULL  out  1  LEVEL == DEPTH.
- DROP_CNT  out  8  saturating count of results lost to overflow.
- FLAG_ERR  out  1  sticky; set when a strobe sees more than one flag set.

## Operation
- **Capture condition:** IN_VALID=1 and exactly one of the four flags is 1. The selected word and tag form the push candidate.
- **Data formation:**
  - Arith_OUT is stored unchanged.
  - Logic, CMP and SHIFT outputs are zero-extended to 2*OP_WIDTH.
- **IN_VALID=1 with zero flags** (ALU NOP with no unit flag): no push, no error.
- **IN_VALID=1 with two or more flags:** no push; FLAG_ERR is set and stays set until CLR or RST.
- **IN_VALID=0:** inputs are ignored regardless of flag state.
- **Push:** occurs when the capture condition holds and the FIFO is not full, or when it is full and a pop happens on the same edge.
- **Pop:** occurs when RES_VALID=1 and RES_READY=1.
- **Overflow:** a push candidate arriving while FULL with no same-edge pop is discarded. DROP_CNT increments and saturates at 255.
- **Simultaneous push and pop:**
  - LEVEL is unchanged.
  - Data order is preserved.
  - When full, the new entry takes the freed slot.
- **Pop when empty** (RES_READY=1, RES_VALID=0): ignored.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. LEVEL is tracked in its own counter.
- **CLR=1:**
  - Empties the FIFO, zeroes DROP_CNT and clears FLAG_ERR on the next edge.
  - Any push or pop in that cycle is ignored.
- **FIFO behaviour:** no bypass. RES_DATA and RES_TAG read the storage at the read pointer and are don't-care while RES_VALID=0.

## Timing
- **Reset values:**
  - RES_VALID=0, LEVEL=0, FULL=0, DROP_CNT=0, FLAG_ERR=0.
  - Pointers = 0.
  - RES_DATA and RES_TAG = 0 (storage cleared).
- **Reset behaviour:** RST asserted at any time, including mid-drain, empties the FIFO immediately without waiting for a clock edge. Queued data is lost.
- **Push latency:** a result captured at edge N is visible with RES_VALID=1 from just after edge N. The earliest pop is at edge N+1.
- **Throughput:** one push and one pop per cycle.
- **Handshake stability:** RES_DATA and RES_TAG are stable while RES_VALID=1 and RES_READY=0.
- **Status update timing:** FULL, LEVEL, DROP_CNT and FLAG_ERR update on the same edge as the event that changes them.

## Test plan
- **Reset and mixed capture:** reset, then 3 strobes:
  - ADD -10+-4 (Arith_Flag) → RES_DATA=32'hFFFF_FFF2, tag 00.
  - AND (Logic_OUT=16'h0000) → tag 01.
  - CMP_OUT=2 (CMP_Flag) → 32'h0000_0002, tag 10.
  - LEVEL=3; drains in order with RES_READY=1.
- **Overflow:** DEPTH=4, RES_READY=0, 6 strobes with SHIFT_OUT=1..6 → FULL=1, DROP_CNT=2. Drain returns 1,2,3,4.
- **Push and pop on the same edge while full:** → LEVEL stays 4, DROP_CNT unchanged. The new value is read out last.
- **Flag errors and idle inputs:**
  - Strobe with Arith_Flag=Logic_Flag=1 → no push, FLAG_ERR=1.
  - Strobe with all flags 0 → no push.
  - IN_VALID=0 with flags set → no push.
- **Async reset mid-drain:** LEVEL=2, assert RST between edges → RES_VALID=0 and LEVEL=0 immediately.
- **Clear and wrap-around:**
  - CLR with LEVEL=3, DROP_CNT=5, FLAG_ERR=1 → all zero after one edge.
  - Then 10 push/pop pairs wrap the pointers with correct data.

Source files
------------

// File: rtl/alu_result_collector.sv
// Collects the single active ALU unit result per strobe into a tagged FIFO
// drained over valid/ready, with overflow-drop counting and a sticky flag-error bit.
module alu_result_collector #(
  parameter int OP_WIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IN_VALID,
  input  logic [2*OP_WIDTH-1:0]           Arith_OUT,
  input  logic                            Arith_Flag,
  input  logic [OP_WIDTH-1:0]             Logic_OUT,
  input  logic                            Logic_Flag,
  input  logic [OP_WIDTH-1:0]             CMP_OUT,
  input  logic                            CMP_Flag,
  input  logic [OP_WIDTH-1:0]             SHIFT_OUT,
  input  logic                            SHIFT_Flag,
  input  logic                            CLR,
  output logic [2*OP_WIDTH-1:0]           RES_DATA,
  output logic [1:0]                      RES_TAG,
  output logic                            RES_VALID,
  input  logic                            RES_READY,
  output logic [$clog2(DEPTH):0]          LEVEL,
  output logic                            FULL,
  output logic [7:0]                      DROP_CNT,
  output logic                            FLAG_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * OP_WIDTH;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_data [DEPTH];
  logic [1:0]    r_tag  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_drop_cnt;
  logic          r_flag_err;

  logic [DW-1:0] w_cand_data;
  logic [1:0]    w_cand_tag;
  logic          w_one_hot;
  logic          w_any_flag;
  logic          w_full;
  logic          w_cand;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_multi;

  // Select the word and tag of the single active unit; narrow results are zero-extended.
  always_comb begin
    w_cand_data = {DW{1'b0}};
    w_cand_tag  = 2'b00;
    w_one_hot   = 1'b0;
    case ({SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag})
      4'b0001: begin
        w_cand_data = Arith_OUT;
        w_cand_tag  = 2'b00;
        w_one_hot   = 1'b1;
      end
      4'b0010: begin
        w_cand_data = {{OP_WIDTH{1'b0}}, Logic_OUT};
        w_cand_tag  = 2'b01;
        w_one_hot   = 1'b1;
      end
      4'b0100: begin
        w_cand_data = {{OP_WIDTH{1'b0}}, CMP_OUT};
        w_cand_tag  = 2'b10;
        w_one_hot   = 1'b1;
      end
      4'b1000: begin
        w_cand_data = {{OP_WIDTH{1'b0}}, SHIFT_OUT};
        w_cand_tag  = 2'b11;
        w_one_hot   = 1'b1;
      end
      default: begin
        w_cand_data = {DW{1'b0}};
        w_cand_tag  = 2'b00;
        w_one_hot   = 1'b0;
      end
    endcase
  end

  assign w_any_flag = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
  assign w_full     = (r_level == FULL_LVL);
  assign w_cand     = IN_VALID & w_one_hot;
  assign w_multi    = IN_VALID & w_any_flag & ~w_one_hot & ~CLR;
  assign w_pop      = (r_level != {(AW+1){1'b0}}) & RES_READY & ~CLR;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_cand & (~w_full | w_pop) & ~CLR;
  assign w_drop     = w_cand & w_full & ~w_pop & ~CLR;

  // Storage and pointers; a clear only rewinds pointers, stale data is never visible.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= {DW{1'b0}};
        r_tag[i]  <= 2'b00;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else if (CLR) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_cand_data;
        r_tag[r_wr_ptr]  <= w_cand_tag;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_level <= {(AW+1){1'b0}};
    end else if (CLR) begin
      r_level <= {(AW+1){1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating drop counter and sticky flag-encoding error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drop_cnt <= 8'd0;
      r_flag_err <= 1'b0;
    end else if (CLR) begin
      r_drop_cnt <= 8'd0;
      r_flag_err <= 1'b0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_multi) begin
        r_flag_err <= 1'b1;
      end
    end
  end

  assign RES_DATA  = r_data[r_rd_ptr];
  assign RES_TAG   = r_tag[r_rd_ptr];
  assign RES_VALID = (r_level != {(AW+1){1'b0}});
  assign LEVEL     = r_level;
  assign FULL      = w_full;
  assign DROP_CNT  = r_drop_cnt;
  assign FLAG_ERR  = r_flag_err;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: directed scenarios followed by random traffic.
module tb_alu_result_collector;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] Arith_OUT = 32'h0;
  logic        Arith_Flag = 1'b0;
  logic [15:0] Logic_OUT = 16'h0;
  logic        Logic_Flag = 1'b0;
  logic [15:0] CMP_OUT = 16'h0;
  logic        CMP_Flag = 1'b0;
  logic [15:0] SHIFT_OUT = 16'h0;
  logic        SHIFT_Flag = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] RES_DATA;
  logic [1:0]  RES_TAG;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [2:0]  LEVEL;
  logic        FULL;
  logic [7:0]  DROP_CNT;
  logic        FLAG_ERR;

  alu_result_collector #(.OP_WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .SHIFT_OUT(SHIFT_OUT), .SHIFT_Flag(SHIFT_Flag),
    .CLR(CLR), .RES_DATA(RES_DATA), .RES_TAG(RES_TAG),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .LEVEL(LEVEL), .FULL(FULL), .DROP_CNT(DROP_CNT), .FLAG_ERR(FLAG_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected contents as {tag, data}, plus status counters.
  logic [33:0] exp_q[$];
  int          m_level = 0;
  int          m_drop  = 0;
  bit          m_err   = 1'b0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    check("level", 34'(LEVEL), 34'(m_level));
    check("full", 34'(FULL), 34'(m_level == DEPTH));
    check("valid", 34'(RES_VALID), 34'(m_level > 0));
    check("drop_cnt", 34'(DROP_CNT), 34'(m_drop));
    check("flag_err", 34'(FLAG_ERR), 34'(m_err));
  endtask

  // Called just after a rising edge: checks status, drives one cycle, updates the model.
  task automatic step(input bit v, input bit [3:0] fl, input bit [31:0] ar,
                      input bit [15:0] lo, input bit [15:0] cm, input bit [15:0] sh,
                      input bit rdy, input bit clr);
    bit pop;
    int nflags;
    logic [33:0] word;
    check_status();
    IN_VALID = v; Arith_Flag = fl[0]; Logic_Flag = fl[1]; CMP_Flag = fl[2]; SHIFT_Flag = fl[3];
    Arith_OUT = ar; Logic_OUT = lo; CMP_OUT = cm; SHIFT_OUT = sh;
    RES_READY = rdy; CLR = clr;
    nflags = $countones(fl);
    pop = (m_level > 0) && rdy && !clr;
    if (clr) begin
      exp_q.delete();
      m_level = 0; m_drop = 0; m_err = 1'b0;
    end else begin
      if (v && nflags > 1) m_err = 1'b1;
      if (v && nflags == 1) begin
        case (fl)
          4'b0001: word = {2'b00, ar};
          4'b0010: word = {2'b01, 16'h0, lo};
          4'b0100: word = {2'b10, 16'h0, cm};
          default: word = {2'b11, 16'h0, sh};
        endcase
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(word);
          m_level++;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (pop) m_level--;
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 4'b0000, 32'h0, 16'h0, 16'h0, 16'h0, rdy, 1'b0);
  endtask

  task automatic push_shift(input bit [15:0] val, input bit rdy);
    step(1'b1, 4'b1000, 32'h0, 16'h0, 16'h0, val, rdy, 1'b0);
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard front.
  always @(negedge CLK) begin
    if (!RST && RES_VALID && RES_READY && !CLR) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected nothing", {RES_TAG, RES_DATA});
      end else begin
        check("head", {RES_TAG, RES_DATA}, exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_data", 34'(RES_DATA), 34'h0);
    check("reset_tag", 34'(RES_TAG), 34'h0);

    // Mixed capture and in-order drain.
    step(1'b1, 4'b0001, 32'hFFFF_FFF2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 32'h0, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 32'h0, 16'h0, 16'h0002, 16'h0, 1'b0, 1'b0);
    check("level_three", 34'(LEVEL), 34'd3);
    repeat (4) idle(1'b1);

    // Overflow: six strobes into a four-entry FIFO.
    for (int i = 1; i <= 6; i++) push_shift(16'(i), 1'b0);
    check("drop_two", 34'(DROP_CNT), 34'd2);
    check("full_set", 34'(FULL), 34'd1);
    // Push and pop on the same edge while full.
    push_shift(16'h0063, 1'b1);
    check("level_four", 34'(LEVEL), 34'd4);
    repeat (5) idle(1'b1);

    // Flag errors and idle inputs.
    step(1'b1, 4'b0011, 32'h1234, 16'h55, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 32'h1, 16'h1, 16'h1, 16'h1, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 32'h1, 16'h1, 16'h1, 16'h1, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 32'h1, 16'h1, 16'h1, 16'h1, 1'b0, 1'b0);
    check("err_sticky", 34'(FLAG_ERR), 34'd1);

    // Asynchronous reset between edges with two entries queued.
    push_shift(16'hA1, 1'b0);
    push_shift(16'hA2, 1'b0);
    idle(1'b0);
    #3 RST = 1'b1;
    #1;
    check("async_valid", 34'(RES_VALID), 34'd0);
    check("async_level", 34'(LEVEL), 34'd0);
    exp_q.delete();
    m_level = 0; m_drop = 0; m_err = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;

    // Clear with LEVEL=3, DROP_CNT=5, FLAG_ERR=1, then pointer wrap-around.
    for (int i = 0; i < 9; i++) push_shift(16'(16'h200 + i), 1'b0);
    step(1'b1, 4'b1100, 32'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    idle(1'b1);
    check("pre_clr_level", 34'(LEVEL), 34'd3);
    check("pre_clr_drop", 34'(DROP_CNT), 34'd5);
    step(1'b1, 4'b0001, 32'hDEAD_BEEF, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    check("clr_level", 34'(LEVEL), 34'd0);
    for (int i = 0; i < 10; i++) push_shift(16'(16'h100 + i), 1'b1);
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit [3:0] fl;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       fl = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) fl = 4'b0000;
      else             fl = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, fl, $urandom, 16'($urandom), 16'($urandom),
           16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end

    for (int k = 0; k < 8 && m_level > 0; k++) idle(1'b1);
    idle(1'b0);
    check("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
